// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: FIFO boundary between the fetch and decode stages.
// Holds {errF, incPCF, instrF} per entry. Absorbs decode stalls and drops every
// queued word on a flush. When empty, decode sees NOP_INSTR with validD low.
// Optional macro FDQ_HALT_STOP_EN: a pushed HALT word (16'h0000) blocks further
// pushes until the next flush or reset.
module fetch_decode_queue #(
    parameter int unsigned DEPTH     = 2,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              instrF,
    input  logic [15:0]              incPCF,
    input  logic                     errF,
    input  logic                     validF,
    output logic                     readyF,
    output logic [15:0]              instrD,
    output logic [15:0]              incPCD,
    output logic                     errD,
    output logic                     validD,
    input  logic                     stallD,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    // Entry layout: {err, incPC, instr}
    logic [32:0]     mem_q [DEPTH];
    logic [32:0]     mem_d [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push;
    logic            pop;

`ifdef FDQ_HALT_STOP_EN
    logic halt_q, halt_d;

    // Latch a pushed HALT word; only flush (or reset) reopens the queue.
    always_comb begin
        halt_d = halt_q;
        if (flush) begin
            halt_d = 1'b0;
        end else if (push && (instrF == 16'h0000)) begin
            halt_d = 1'b1;
        end
    end

    // Halt flag register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end

    assign readyF = (count_q != FullCnt) && !halt_q;
`else
    // No full-bypass: a pop in the same cycle does not reopen a full queue.
    assign readyF = (count_q != FullCnt);
`endif

    assign validD = (count_q != '0);
    assign push   = validF && readyF && !flush;
    assign pop    = validD && !stallD && !flush;
    assign count  = count_q;

    // Head presentation; NOP when nothing is queued.
    always_comb begin
        instrD = NOP_INSTR;
        incPCD = 16'h0000;
        errD   = 1'b0;
        if (validD) begin
            instrD = mem_q[rd_ptr_q][15:0];
            incPCD = mem_q[rd_ptr_q][31:16];
            errD   = mem_q[rd_ptr_q][32];
        end
    end

    // Pointer, occupancy and storage next-state; flush overrides everything.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {errF, incPCF, instrF};
                wr_ptr_d        = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    // Control state with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset; unread slots are never presented.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Self-checking bench for fetch_decode_queue: directed scenarios plus a random
// run checked against a queue-based model of the fetch/decode handshake.
module tb_fetch_decode_queue;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [15:0] NOP = 16'h0800;

    logic            clk;
    logic            rst;
    logic [15:0]     instrF;
    logic [15:0]     incPCF;
    logic            errF;
    logic            validF;
    logic            readyF;
    logic [15:0]     instrD;
    logic [15:0]     incPCD;
    logic            errD;
    logic            validD;
    logic            stallD;
    logic            flush;
    logic [CW-1:0]   count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic        err;
    } ent_t;

    ent_t mq[$];
    bit   m_halt = 0;

    fetch_decode_queue #(
        .DEPTH     (DEPTH),
        .NOP_INSTR (NOP)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .instrF (instrF),
        .incPCF (incPCF),
        .errF   (errF),
        .validF (validF),
        .readyF (readyF),
        .instrD (instrD),
        .incPCD (incPCD),
        .errD   (errD),
        .validD (validD),
        .stallD (stallD),
        .flush  (flush),
        .count  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected values derived from the model queue.
    function automatic bit m_ready();
        return (mq.size() != DEPTH) && !m_halt;
    endfunction

    function automatic logic [15:0] e_instr();
        return (mq.size() != 0) ? mq[0].instr : NOP;
    endfunction

    function automatic logic [15:0] e_pc();
        return (mq.size() != 0) ? mq[0].pc : 16'h0000;
    endfunction

    function automatic logic e_err();
        return (mq.size() != 0) ? mq[0].err : 1'b0;
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        bit   push;
        bit   pop;
        ent_t e;
        push = validF && m_ready() && !flush;
        pop  = (mq.size() != 0) && !stallD && !flush;
        if (flush) begin
            mq.delete();
            m_halt = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                e.instr = instrF;
                e.pc    = incPCF;
                e.err   = errF;
                mq.push_back(e);
`ifdef FDQ_HALT_STOP_EN
                if (instrF == 16'h0000) m_halt = 1;
`endif
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                         input logic er, input logic st, input logic fl);
        validF = v;
        instrF = ins;
        incPCF = pc;
        errF   = er;
        stallD = st;
        flush  = fl;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b1, 16'h1234, 16'h0002, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (validD !== 1'b0) begin
            n_fail++; $display("FAIL reset_validD: got %b want 0", validD);
        end
        n_checks++;
        if (instrD !== NOP) begin
            n_fail++; $display("FAIL reset_instrD: got %h want %h", instrD, NOP);
        end
        n_checks++;
        if (count !== '0 || readyF !== 1'b1) begin
            n_fail++; $display("FAIL reset_count_ready: got %0d/%b want 0/1", count, readyF);
        end
        n_checks++;
        if (incPCD !== 16'h0000 || errD !== 1'b0) begin
            n_fail++; $display("FAIL reset_pc_err: got %h/%b want 0000/0", incPCD, errD);
        end
        mq.delete();
        m_halt = 0;
        rst = 1'b1;
        #1;
        tick();
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (instrD !== 16'h1234 || incPCD !== 16'h0002 || validD !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_push: got %h/%h/%b want 1234/0002/1", instrD, incPCD, validD);
        end
        stallD = 1'b0;
        tick();
        n_checks++;
        if (count !== '0 || validD !== 1'b0) begin
            n_fail++; $display("FAIL reset_drain: got %0d/%b want 0/0", count, validD);
        end
    endtask

    task automatic test_stream();
        logic [15:0] w;
        for (int i = 1; i <= 3; i++) begin
            w = 16'hA000 + 16'(i);
            drive(1'b1, w, 16'(2 * i), 1'b0, 1'b0, 1'b0);
            tick();
            n_checks++;
            if (instrD !== w || count !== CW'(1) || incPCD !== 16'(2 * i)) begin
                n_fail++;
                $display("FAIL stream_%0d: got %h cnt %0d pc %h want %h cnt 1 pc %h",
                         i, instrD, count, incPCD, w, 16'(2 * i));
            end
        end
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (count !== '0 || instrD !== NOP) begin
            n_fail++; $display("FAIL stream_drain: got %0d/%h want 0/%h", count, instrD, NOP);
        end
    endtask

    task automatic test_fill_stall();
        drive(1'b1, 16'hB001, 16'h0010, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 16'hB002, 16'h0012, 1'b0, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (count !== CW'(2) || readyF !== 1'b0 || instrD !== 16'hB001) begin
            n_fail++;
            $display("FAIL fill_full: got cnt %0d rdy %b instr %h want 2/0/b001", count, readyF, instrD);
        end
        drive(1'b1, 16'hB003, 16'h0014, 1'b0, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (count !== CW'(2) || instrD !== 16'hB001 || incPCD !== 16'h0010) begin
            n_fail++;
            $display("FAIL fill_reject: got cnt %0d instr %h pc %h want 2/b001/0010", count, instrD, incPCD);
        end
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (instrD !== 16'hB002 || readyF !== 1'b1 || count !== CW'(1)) begin
            n_fail++;
            $display("FAIL fill_pop1: got %h rdy %b cnt %0d want b002/1/1", instrD, readyF, count);
        end
        tick();
        n_checks++;
        if (validD !== 1'b0 || count !== '0) begin
            n_fail++; $display("FAIL fill_pop2: got %b/%0d want 0/0", validD, count);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 16'hF001, 16'h0020, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 16'hF002, 16'h0022, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 16'hC001, 16'h0030, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (count !== '0 || validD !== 1'b0 || instrD !== NOP || readyF !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_empty: got cnt %0d v %b instr %h rdy %b want 0/0/%h/1",
                     count, validD, instrD, readyF, NOP);
        end
        tick();
        n_checks++;
        if (validD !== 1'b0 || instrD !== NOP) begin
            n_fail++; $display("FAIL flush_not_stored: got %b/%h want 0/%h", validD, instrD, NOP);
        end
    endtask

    task automatic test_error();
        drive(1'b1, 16'hD001, 16'h0040, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (instrD !== 16'hD001 || errD !== 1'b0) begin
            n_fail++; $display("FAIL err_d001: got %h/%b want d001/0", instrD, errD);
        end
        drive(1'b1, 16'hD002, 16'h0042, 1'b1, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (instrD !== 16'hD002 || errD !== 1'b1) begin
            n_fail++; $display("FAIL err_d002: got %h/%b want d002/1", instrD, errD);
        end
        drive(1'b1, 16'hD003, 16'h0044, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (instrD !== 16'hD003 || errD !== 1'b0) begin
            n_fail++; $display("FAIL err_not_sticky: got %h/%b want d003/0", instrD, errD);
        end
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_halt();
        drive(1'b1, 16'h0000, 16'h0050, 1'b0, 1'b1, 1'b0);
        tick();
`ifdef FDQ_HALT_STOP_EN
        n_checks++;
        if (readyF !== 1'b0 || count !== CW'(1)) begin
            n_fail++; $display("FAIL halt_block: got rdy %b cnt %0d want 0/1", readyF, count);
        end
        drive(1'b1, 16'hE001, 16'h0052, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 16'hE001, 16'h0052, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (count !== '0 || validD !== 1'b0 || readyF !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_drain: got cnt %0d v %b rdy %b want 0/0/0", count, validD, readyF);
        end
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        tick();
        flush = 1'b0;
        n_checks++;
        if (readyF !== 1'b1) begin
            n_fail++; $display("FAIL halt_flush_clear: got rdy %b want 1", readyF);
        end
`else
        n_checks++;
        if (readyF !== 1'b1 || count !== CW'(1) || instrD !== 16'h0000) begin
            n_fail++;
            $display("FAIL no_halt: got rdy %b cnt %0d instr %h want 1/1/0000", readyF, count, instrD);
        end
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick();
`endif
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 16'h7001, 16'h0060, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 16'h7002, 16'h0062, 1'b0, 1'b1, 1'b0);
        tick();
        #3;
        rst = 1'b0;
        #1;
        n_checks++;
        if (count !== '0 || validD !== 1'b0 || readyF !== 1'b1 || instrD !== NOP) begin
            n_fail++;
            $display("FAIL reset_async: got cnt %0d v %b rdy %b instr %h want 0/0/1/%h",
                     count, validD, readyF, instrD, NOP);
        end
        mq.delete();
        m_halt = 0;
        #1;
        rst = 1'b1;
        drive(1'b1, 16'h5555, 16'h0070, 1'b0, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (instrD !== 16'h5555 || count !== CW'(1)) begin
            n_fail++; $display("FAIL reset_restart: got %h/%0d want 5555/1", instrD, count);
        end
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 2000; i++) begin
            validF = ($urandom_range(0, 9) < 7);
            instrF = ($urandom_range(0, 31) == 0) ? 16'h0000 : 16'($urandom);
            incPCF = 16'($urandom);
            errF   = ($urandom_range(0, 3) == 0);
            stallD = ($urandom_range(0, 9) < 4);
            flush  = ($urandom_range(0, 19) == 0);
            n_checks++;
            if (readyF !== m_ready()) begin
                n_fail++; bad++;
                if (bad < 10) $display("FAIL rand_ready[%0d]: got %b want %b", i, readyF, m_ready());
            end
            tick();
            n_checks++;
            if (validD !== (mq.size() != 0) || instrD !== e_instr() || incPCD !== e_pc()
                || errD !== e_err() || count !== CW'(mq.size())) begin
                n_fail++; bad++;
                if (bad < 10)
                    $display("FAIL rand_head[%0d]: got v%b %h %h %b c%0d want v%b %h %h %b c%0d",
                             i, validD, instrD, incPCD, errD, count, (mq.size() != 0),
                             e_instr(), e_pc(), e_err(), mq.size());
            end
        end
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        tick();
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill_stall();
        test_flush();
        test_error();
        test_halt();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
